core_fetch_prefetch: RTL and testbench
======================================

Name: core_fetch_prefetch

Overview:
Parametrised prefetching instruction-fetch stage for the RV32 core.
- Decouples I-mem access from the EXEC handshake through a DEPTH-entry instruction queue of {pc, instr} pairs.
- Keeps fetching sequentially while the queue has space.
- Flushes the queue and redirects on a new PC from EXEC.
- Sits between the I-mem port and the controller/EXEC stage.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
DEPTH, 4, queue entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fetch_valid  out  1  queue head holds a valid instruction
fetch_ready  in  1  controller/EXEC consumes head this cycle
instr  out  32  head instruction
pc  out  32  head PC
pc_plus_4  out  32  head PC + 4, for write-back mux
pc_new_valid  in  1  redirect request from EXEC
pc_new  in  32  redirect target
imem_valid  out  1  I-mem request
imem_ready  in  1  I-mem accept; imem_rdata valid in the same cycle
imem_addr  out  32  request address
imem_rdata  in  32  instruction word
occupancy  out  CNT_W  number of valid queue entries (debug/perf)

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- State:
  - fetch_pc: next address to request.
  - Queue storage: DEPTH x {pc, instr}, not reset.
  - rd_ptr, wr_ptr: log2(DEPTH) bits each, wrap modulo DEPTH.
  - count: 0..DEPTH.
- Reset values: fetch_pc=RESET_VECTOR, rd_ptr=wr_ptr=0, count=0.
- Outputs immediately after reset: fetch_valid=0, occupancy=0, imem_valid=1, imem_addr=RESET_VECTOR.
- Request side:
  - imem_valid = (count != DEPTH) & ~pc_new_valid.
  - imem_addr = fetch_pc.
  - push = imem_valid & imem_ready.
  - On push: write {fetch_pc, imem_rdata} at wr_ptr, wr_ptr++, fetch_pc += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Consume side:
  - fetch_valid = (count != 0).
  - instr/pc are driven combinationally from the head entry; they are don't-care when fetch_valid=0.
  - pc_plus_4 = pc + 4.
  - pop = fetch_valid & fetch_ready; on pop, rd_ptr++.
- count update: push only: +1; pop only: -1; push and pop together: unchanged.
- Full/empty boundaries:
  - When full, imem_valid=0. It does not rise in the same cycle as a pop (no combinational fetch_ready->imem_valid path); it rises the next cycle.
  - When empty, a push makes fetch_valid=1 on the next cycle. There is no same-cycle bypass, so minimum latency from I-mem accept to fetch_valid is 1 cycle.
- Redirect (pc_new_valid=1), which has priority over everything else:
  - Next cycle: count=0, rd_ptr=wr_ptr=0, fetch_pc = {pc_new[31:2], 2'b00}. Low 2 bits of pc_new are ignored.
  - Any pop in the redirect cycle is still a valid consume for the controller; queue state is discarded regardless.
  - imem_valid=0 during the redirect cycle, so no stale push can occur.
  - The first request to the new target is issued the following cycle.
- I-mem stall: imem_valid stays high with a stable imem_addr until imem_ready, or until a redirect. On redirect the request is withdrawn and the address changes; I-mem is combinational-accept and tolerates this.
- Throughput: with imem_ready=1 and fetch_ready=1 continuously, one instruction per cycle is sustained after the initial 1-cycle fill.
- Reset mid-operation: all state returns to reset values asynchronously; queue contents are lost and are not observable because fetch_valid=0.
- occupancy = count, registered.

Decomposition:
- core_pkg gains:
  - typedef fetch_entry_t: struct packed {logic [31:0] pc; logic [31:0] instr;}
  - constant INSTR_BYTES = 4.
- Natural sub-module: core_sync_fifo.
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop/flush, head data, count.
  - Instantiated with WIDTH=$bits(fetch_entry_t).
- The PC register, redirect logic and request gating stay in core_fetch_prefetch.

Test Plan:
- Reset, imem_ready=1, fetch_ready=0, DEPTH=4:
  - Pushes at addresses 0,4,8,C; imem_valid drops after the 4th accept and occupancy=4.
  - Head pc=0, pc_plus_4=4, instr = word at address 0.
- Streaming, imem_ready=1 and fetch_ready=1:
  - fetch_valid rises 1 cycle after the first accept.
  - Consecutive cycles deliver pc=0,4,8,...; occupancy is steady at 1.
- Redirect with occupancy=3 and pc_new=32'h0000_1002:
  - Next cycle: fetch_valid=0, occupancy=0, imem_addr=32'h0000_1000.
  - No push in the redirect cycle; the first delivered pc is 32'h0000_1000.
- I-mem stall, imem_ready=0 for 5 cycles while the consumer drains:
  - imem_addr is held constant; fetch_valid falls when the queue empties.
  - After imem_ready returns, the stalled instruction is delivered next.
- Wrap, redirect to 32'hFFFF_FFF8:
  - Delivered pcs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - pc_plus_4 for FFFF_FFFC is 0.
- Full with simultaneous pop, count=DEPTH and fetch_ready=1:
  - occupancy goes to DEPTH-1 and imem_valid=1 next cycle, never in the same cycle.
  - Assertion: no push ever occurs while full.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types and constants.
//   fetch_entry_t : one prefetch queue entry, {pc, instr}
//   INSTR_BYTES   : byte stride between sequential instructions
package core_pkg;

   localparam logic [31:0] INSTR_BYTES = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/core_sync_fifo.sv
// Synchronous FIFO with a flush input and an unregistered head read.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push_i, wdata_i   : write request and data (ignored when full)
//   pop_i             : remove the head entry (ignored when empty)
//   flush_i           : empty the FIFO; overrides push and pop
//   rdata_o           : head entry, meaningful only when not empty
//   count_o           : number of valid entries, 0..DEPTH
//   full_o, empty_o   : occupancy flags
module core_sync_fifo #(
   parameter  int unsigned WIDTH = 64,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_d = count_q + 1'b1;
         else if (!do_push && do_pop) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset; empty_o masks stale contents.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/core_fetch_prefetch.sv
// Prefetching instruction-fetch stage. Requests sequential words from I-mem
// while the instruction queue has room and presents the queue head to EXEC.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   fetch_valid/fetch_ready        : head handshake towards the controller
//   instr, pc, pc_plus_4           : head entry (don't-care when !fetch_valid)
//   pc_new_valid, pc_new           : redirect request, flushes the queue
//   imem_valid/imem_ready          : I-mem request, data returned on accept
//   imem_addr, imem_rdata          : request address, instruction word
//   occupancy                      : queue entry count (debug/perf)
module core_fetch_prefetch
   import core_pkg::*;
#(
   parameter  logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter  int unsigned DEPTH        = 4,
   localparam int unsigned CNT_W        = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             fetch_valid,
   input  logic             fetch_ready,
   output logic [31:0]      instr,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus_4,
   input  logic             pc_new_valid,
   input  logic [31:0]      pc_new,
   output logic             imem_valid,
   input  logic             imem_ready,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [CNT_W-1:0] occupancy
);

   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic         q_full, q_empty;
   logic         push, pop;
   fetch_entry_t wr_entry, head;
   logic [$bits(fetch_entry_t)-1:0] head_raw;
   logic         unused_pc_new_lsbs;

   assign unused_pc_new_lsbs = ^pc_new[1:0];

   // Gating only on the registered full flag keeps fetch_ready out of the
   // imem_valid cone: a pop from a full queue re-opens requests next cycle.
   assign imem_valid = ~q_full & ~pc_new_valid;
   assign imem_addr  = fetch_pc_q;
   assign push       = imem_valid & imem_ready;
   assign fetch_valid = ~q_empty;
   assign pop        = fetch_valid & fetch_ready;

   assign wr_entry = '{pc: fetch_pc_q, instr: imem_rdata};
   assign head     = fetch_entry_t'(head_raw);
   assign instr    = head.instr;
   assign pc       = head.pc;
   assign pc_plus_4 = head.pc + INSTR_BYTES;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (pc_new_valid)  fetch_pc_d = {pc_new[31:2], 2'b00};
      else if (push)     fetch_pc_d = fetch_pc_q + INSTR_BYTES;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fetch_pc_q <= RESET_VECTOR;
      else        fetch_pc_q <= fetch_pc_d;
   end

   core_sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i (wr_entry),
      .pop_i   (pop),
      .flush_i (pc_new_valid),
      .rdata_o (head_raw),
      .count_o (occupancy),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

endmodule

// File: tb/tb_core_fetch_prefetch.sv
module tb_core_fetch_prefetch;
   import core_pkg::*;

   localparam int          DEPTH = 4;
   localparam int          CNT_W = $clog2(DEPTH) + 1;
   localparam logic [31:0] RV    = 32'h0000_0000;

   logic             clk;
   logic             rst_n;
   logic             fetch_valid;
   logic             fetch_ready;
   logic [31:0]      instr;
   logic [31:0]      pc;
   logic [31:0]      pc_plus_4;
   logic             pc_new_valid;
   logic [31:0]      pc_new;
   logic             imem_valid;
   logic             imem_ready;
   logic [31:0]      imem_addr;
   logic [31:0]      imem_rdata;
   logic [CNT_W-1:0] occupancy;

   core_fetch_prefetch #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fetch_valid  (fetch_valid),
      .fetch_ready  (fetch_ready),
      .instr        (instr),
      .pc           (pc),
      .pc_plus_4    (pc_plus_4),
      .pc_new_valid (pc_new_valid),
      .pc_new       (pc_new),
      .imem_valid   (imem_valid),
      .imem_ready   (imem_ready),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .occupancy    (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0010_0013 + (a << 5);
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference model: a queue of {pc, instr} plus the next fetch address.
   // Inputs only change just after posedge, so the values seen at negedge
   // are the ones the DUT will sample at the next posedge.
   fetch_entry_t mq[$];
   logic [31:0]  m_fpc;
   int           m_occ;
   bit           m_iv;

   always @(negedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_fpc = RV;
      end else begin
         m_occ = mq.size();
         m_iv  = (m_occ != DEPTH) && !pc_new_valid;
         chk("m_fetch_valid", {31'd0, fetch_valid}, {31'd0, m_occ != 0});
         chk("m_occupancy", 32'(occupancy), 32'(m_occ));
         chk("m_imem_valid", {31'd0, imem_valid}, {31'd0, m_iv});
         chk("m_imem_addr", imem_addr, m_fpc);
         chk("no_push_when_full",
             {31'd0, imem_valid && imem_ready && (32'(occupancy) == DEPTH)}, 32'd0);
         if (m_occ != 0) begin
            chk("m_pc", pc, mq[0].pc);
            chk("m_instr", instr, mq[0].instr);
            chk("m_pc_plus_4", pc_plus_4, mq[0].pc + 32'd4);
         end
         if (pc_new_valid) begin
            mq.delete();
            m_fpc = {pc_new[31:2], 2'b00};
         end else begin
            if (m_occ != 0 && fetch_ready) void'(mq.pop_front());
            if (m_iv && imem_ready) begin
               mq.push_back('{pc: m_fpc, instr: mem_word(m_fpc)});
               m_fpc = m_fpc + 32'd4;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; fetch_ready = 1'b0; imem_ready = 1'b1;
      pc_new_valid = 1'b0; pc_new = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_imem_valid", {31'd0, imem_valid}, 32'd1);
      chk("rst_imem_addr", imem_addr, 32'h0);

      // fill with no consumer
      for (int i = 0; i < 4; i++) begin
         chk("fill_addr", imem_addr, 32'(i * 4));
         cyc();
      end
      chk("full_imem_valid", {31'd0, imem_valid}, 32'd0);
      chk("full_occupancy", 32'(occupancy), 32'd4);
      chk("full_head_valid", {31'd0, fetch_valid}, 32'd1);
      chk("full_head_pc", pc, 32'h0);
      chk("full_head_pc4", pc_plus_4, 32'h4);
      chk("full_head_instr", instr, 32'h0010_0013);
      cyc();
      chk("full_hold_iv", {31'd0, imem_valid}, 32'd0);

      // pop while full: imem_valid only rises the cycle after
      fetch_ready = 1'b1;
      #1;
      chk("full_pop_same_iv", {31'd0, imem_valid}, 32'd0);
      cyc();
      fetch_ready = 1'b0;
      #1;
      chk("full_pop_occ", 32'(occupancy), 32'd3);
      chk("full_pop_next_iv", {31'd0, imem_valid}, 32'd1);
      chk("full_pop_head", pc, 32'h4);
      cyc();
      fetch_ready = 1'b1; imem_ready = 1'b0;
      cyc();

      // redirect with three entries queued
      pc_new_valid = 1'b1; pc_new = 32'h0000_1002; fetch_ready = 1'b0; imem_ready = 1'b1;
      #1;
      chk("redir_iv", {31'd0, imem_valid}, 32'd0);
      chk("redir_occ_before", 32'(occupancy), 32'd3);
      cyc();
      pc_new_valid = 1'b0; fetch_ready = 1'b1;
      #1;
      chk("redir_fv", {31'd0, fetch_valid}, 32'd0);
      chk("redir_occ", 32'(occupancy), 32'd0);
      chk("redir_addr", imem_addr, 32'h0000_1000);

      // streaming
      cyc();
      chk("stream_pc0", pc, 32'h0000_1000);
      chk("stream_occ0", 32'(occupancy), 32'd1);
      cyc();
      chk("stream_pc1", pc, 32'h0000_1004);
      chk("stream_occ1", 32'(occupancy), 32'd1);
      cyc();
      chk("stream_pc2", pc, 32'h0000_1008);
      fetch_ready = 1'b0;
      cyc();
      cyc();
      chk("prestall_occ", 32'(occupancy), 32'd3);

      // I-mem stall while the consumer drains
      imem_ready = 1'b0; fetch_ready = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_addr", imem_addr, 32'h0000_1014);
         chk("stall_iv", {31'd0, imem_valid}, 32'd1);
         cyc();
      end
      chk("stall_drained_fv", {31'd0, fetch_valid}, 32'd0);
      imem_ready = 1'b1;
      #1;
      chk("stall_release_addr", imem_addr, 32'h0000_1014);
      cyc();
      chk("stall_deliver_fv", {31'd0, fetch_valid}, 32'd1);
      chk("stall_deliver_pc", pc, 32'h0000_1014);
      chk("stall_deliver_instr", instr, 32'h0012_0293);

      // address wrap
      pc_new_valid = 1'b1; pc_new = 32'hFFFF_FFF8;
      cyc();
      pc_new_valid = 1'b0;
      cyc();
      chk("wrap_pc0", pc, 32'hFFFF_FFF8);
      chk("wrap_pc4_0", pc_plus_4, 32'hFFFF_FFFC);
      cyc();
      chk("wrap_pc1", pc, 32'hFFFF_FFFC);
      chk("wrap_pc4_1", pc_plus_4, 32'h0000_0000);
      cyc();
      chk("wrap_pc2", pc, 32'h0000_0000);

      // asynchronous reset mid-operation
      #2 rst_n = 1'b0;
      #1;
      chk("arst_fv", {31'd0, fetch_valid}, 32'd0);
      chk("arst_occ", 32'(occupancy), 32'd0);
      chk("arst_iv", {31'd0, imem_valid}, 32'd1);
      chk("arst_addr", imem_addr, RV);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; fetch_ready = 1'b0;
      cyc(); cyc(); cyc();
      chk("post_rst_occ", 32'(occupancy), 32'd3);
      chk("post_rst_head", pc, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
